// File: rtl/alu_issue_arbiter.sv
// Two-slot issue arbiter in front of one shared combinational ALU.
// It grants one slot per cycle (round-robin on conflict) and keeps the result in a single registered output entry.
module alu_issue_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [31:0]      alu_x,
    output logic [31:0]      alu_y,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_res,
    input  logic             alu_ovf,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_res,
    output logic             rsp_ovf,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,

    output logic [15:0]      conflict_cnt
);

    logic             r_rsp_valid;
    logic [31:0]      r_rsp_res;
    logic             r_rsp_ovf;
    logic             r_rsp_src;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rr_last;
    logic [15:0]      r_conflict_cnt;

    logic             w_free;
    logic             w_any_valid;
    logic             w_both_valid;
    logic             w_gnt_idx;
    logic             w_accept;
    logic [TAG_W-1:0] w_gnt_tag;

    assign w_free       = !r_rsp_valid || rsp_ready;
    assign w_any_valid  = req0_valid || req1_valid;
    assign w_both_valid = req0_valid && req1_valid;
    assign w_accept     = w_free && w_any_valid;

    // Round-robin only matters on a conflict; a lone requester always wins.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path can infer a latch.
        w_gnt_idx = 1'b0;
        if (w_both_valid) begin
            w_gnt_idx = ~r_rr_last;
        end else if (req1_valid) begin
            w_gnt_idx = 1'b1;
        end
    end

    // Ready is gated by rst so nothing is offered while the result register is held in reset.
    assign req0_ready = !rst && w_accept && (w_gnt_idx == 1'b0);
    assign req1_ready = !rst && w_accept && (w_gnt_idx == 1'b1);

    always_comb begin
        alu_x     = '0;
        alu_y     = '0;
        alu_op    = '0;
        w_gnt_tag = '0;
        if (w_any_valid) begin
            if (w_gnt_idx) begin
                alu_x     = req1_x;
                alu_y     = req1_y;
                alu_op    = req1_op;
                w_gnt_tag = req1_tag;
            end else begin
                alu_x     = req0_x;
                alu_y     = req0_y;
                alu_op    = req0_op;
                w_gnt_tag = req0_tag;
            end
        end
    end

    // Output entry: a new acceptance wins over a drain, which gives 1 op/cycle back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_src   <= 1'b0;
            r_rsp_tag   <= '0;
            r_rr_last   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_res   <= alu_res;
                r_rsp_ovf   <= alu_ovf;
                r_rsp_src   <= w_gnt_idx;
                r_rsp_tag   <= w_gnt_tag;
                r_rr_last   <= w_gnt_idx;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_both_valid && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_res      = r_rsp_res;
    assign rsp_ovf      = r_rsp_ovf;
    assign rsp_src      = r_rsp_src;
    assign rsp_tag      = r_rsp_tag;
    assign conflict_cnt = r_conflict_cnt;

    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
        (!req0_ready || req0_valid) && (!req1_ready || req1_valid));

    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable({rsp_res, rsp_ovf, rsp_src, rsp_tag})));

    a_cnt_saturates: assert property (@(posedge clk) disable iff (rst)
        (conflict_cnt == 16'hFFFF) |=> (conflict_cnt == 16'hFFFF));

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// The shared ALU is modelled here as the environment around the arbiter.
module tb_alu_issue_arbiter;

    localparam int TAG_W = 4;
    localparam int RW    = 35 + TAG_W;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_x, req0_y, req1_x, req1_y;
    logic [3:0]       req0_op, req1_op;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      alu_x, alu_y, alu_res;
    logic [3:0]       alu_op;
    logic             alu_ovf;
    logic             rsp_valid, rsp_ready, rsp_ovf, rsp_src;
    logic [31:0]      rsp_res;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: one output entry, last winner, conflict count.
    bit               m_valid;
    logic [31:0]      m_res;
    bit               m_ovf;
    bit               m_src;
    logic [TAG_W-1:0] m_tag;
    int               m_last;
    int               m_cnt;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_op(req1_op), .req1_tag(req1_tag),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_res(alu_res), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .conflict_cnt(conflict_cnt)
    );

    // Shared ALU: add/sub with signed overflow, logic ops; unknown ops echo x and flag ovf from op[3].
    function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        logic [31:0] r;
        logic        v;
        case (op)
            4'd0:    begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
            4'd1:    begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
            4'd2:    begin r = x & y; v = 1'b0; end
            4'd3:    begin r = x | y; v = 1'b0; end
            4'd4:    begin r = x ^ y; v = 1'b0; end
            default: begin r = x;     v = op[3]; end
        endcase
        return {v, r};
    endfunction

    always_comb {alu_ovf, alu_res} = alu_fn(alu_x, alu_y, alu_op);

    function automatic int pick();
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_free();
        return !m_valid || rsp_ready;
    endfunction

    function automatic logic [RW-1:0] dut_rsp();
        return {rsp_valid, rsp_res, rsp_ovf, rsp_src, rsp_tag};
    endfunction

    function automatic logic [RW-1:0] model_rsp();
        return {m_valid, m_res, m_ovf, m_src, m_tag};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_res = '0; m_ovf = 0; m_src = 0; m_tag = '0; m_last = 1; m_cnt = 0;
    endtask

    // Applies one rising edge of the specification's rules to the model (inputs are stable here).
    task automatic model_edge();
        int          g;
        logic [32:0] r;
        if (rst) begin
            model_reset();
            return;
        end
        g = pick();
        if (req0_valid && req1_valid && m_cnt < 65535) m_cnt++;
        if (g >= 0 && m_free()) begin
            r       = (g == 1) ? alu_fn(req1_x, req1_y, req1_op) : alu_fn(req0_x, req0_y, req0_op);
            m_valid = 1;
            m_res   = r[31:0];
            m_ovf   = r[32];
            m_src   = (g == 1);
            m_tag   = (g == 1) ? req1_tag : req0_tag;
            m_last  = g;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req0(input bit v, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] op, input int tag);
        req0_valid = v; req0_x = x; req0_y = y; req0_op = op; req0_tag = TAG_W'(tag);
    endtask

    task automatic set_req1(input bit v, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] op, input int tag);
        req1_valid = v; req1_x = x; req1_y = y; req1_op = op; req1_tag = TAG_W'(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        clk_edge();
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [RW-1:0] zero_rsp;
        zero_rsp = '0;
        rst = 1'b1;
        model_reset();
        set_req0(1, 32'd1, 32'd2, ALU_ADD, 1);
        set_req1(1, 32'd3, 32'd4, ALU_ADD, 2);
        rsp_ready = 1'b1;
        repeat (2) clk_edge();
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        n_cmp++;
        if (dut_rsp() !== zero_rsp) begin
            n_err++; $display("FAIL reset_rsp: got %h expected %h", dut_rsp(), zero_rsp);
        end
        n_cmp++;
        if (conflict_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release_no_accept: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_single();
        logic [RW-1:0] exp;
        @(negedge clk);
        set_req0(1, 32'd5, 32'd7, ALU_ADD, 3);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        n_cmp++;
        if ({alu_x, alu_y, alu_op} !== {32'd5, 32'd7, ALU_ADD}) begin
            n_err++; $display("FAIL single_alu_mux: got %h/%h/%h expected 5/7/0", alu_x, alu_y, alu_op);
        end
        clk_edge();
        exp = {1'b1, 32'd12, 1'b0, 1'b0, TAG_W'(3)};
        n_cmp++;
        if (dut_rsp() !== exp) begin
            n_err++; $display("FAIL single_rsp: got %h expected %h", dut_rsp(), exp);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({alu_x, alu_y, alu_op} !== '0) begin
            n_err++; $display("FAIL idle_alu_zero: got %h/%h/%h expected 0/0/0", alu_x, alu_y, alu_op);
        end
        clk_edge();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_conflict();
        int exp_g [4] = '{0, 1, 0, 1};
        do_reset();
        set_req0(1, 32'd10, 32'd20, ALU_ADD, 1);
        set_req1(1, 32'd100, 32'd1, ALU_SUB, 2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== ((exp_g[i] == 1) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL conflict_ready[%0d]: got r1r0=%b expected grant %0d", i,
                                  {req1_ready, req0_ready}, exp_g[i]);
            end
            clk_edge();
            n_cmp++;
            if ({rsp_valid, rsp_src, rsp_res} !== {1'b1, exp_g[i] == 1, (exp_g[i] == 1) ? 32'd99 : 32'd30}) begin
                n_err++; $display("FAIL conflict_rsp[%0d]: got v=%b src=%b res=%0d expected src=%0d", i,
                                  rsp_valid, rsp_src, rsp_res, exp_g[i]);
            end
            n_cmp++;
            if (conflict_cnt !== 16'(i + 1)) begin
                n_err++; $display("FAIL conflict_cnt[%0d]: got %0d expected %0d", i, conflict_cnt, i + 1);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clk_edge();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] held;
        int            cnt0;
        @(negedge clk);
        set_req0(1, 32'd40, 32'd2, ALU_SUB, 7);
        rsp_ready = 1'b0;
        clk_edge();
        held = {1'b1, 32'd38, 1'b0, 1'b0, TAG_W'(7)};
        cnt0 = int'(conflict_cnt);
        @(negedge clk);
        set_req0(1, 32'd1, 32'd1, ALU_ADD, 8);
        set_req1(1, 32'd6, 32'd3, 4'd2, 9);
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, {req0_ready, req1_ready});
            end
            clk_edge();
            n_cmp++;
            if (dut_rsp() !== held) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, dut_rsp(), held);
            end
            n_cmp++;
            if (int'(conflict_cnt) !== cnt0 + k) begin
                n_err++; $display("FAIL bp_cnt[%0d]: got %0d expected %0d", k, conflict_cnt, cnt0 + k);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_drain_grant: got r0r1=%b expected 01", {req0_ready, req1_ready});
        end
        clk_edge();
        n_cmp++;
        if (dut_rsp() !== {1'b1, 32'd2, 1'b0, 1'b1, TAG_W'(9)}) begin
            n_err++; $display("FAIL bp_no_bubble: got %h expected %h", dut_rsp(),
                              {1'b1, 32'd2, 1'b0, 1'b1, TAG_W'(9)});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clk_edge();
    endtask

    task automatic test_overflow();
        @(negedge clk);
        set_req1(1, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 5);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL ovf_ready: got r0r1=%b expected 01", {req0_ready, req1_ready});
        end
        clk_edge();
        n_cmp++;
        if ({rsp_valid, rsp_res, rsp_ovf, rsp_src, rsp_tag} !== {1'b1, 32'h8000_0000, 1'b1, 1'b1, TAG_W'(5)}) begin
            n_err++; $display("FAIL ovf_rsp: got v=%b res=%h ovf=%b src=%b tag=%0d expected 1/80000000/1/1/5",
                              rsp_valid, rsp_res, rsp_ovf, rsp_src, rsp_tag);
        end
        @(negedge clk);
        set_req1(1, 32'hCAFE_0001, 32'd3, 4'hF, 6);
        #1;
        n_cmp++;
        if (alu_op !== 4'hF) begin
            n_err++; $display("FAIL op_passthru: got %h expected f", alu_op);
        end
        clk_edge();
        n_cmp++;
        if ({rsp_res, rsp_ovf} !== {32'hCAFE_0001, 1'b1}) begin
            n_err++; $display("FAIL ovf_unmasked: got res=%h ovf=%b expected cafe0001/1", rsp_res, rsp_ovf);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        clk_edge();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req0(1, 32'd9, 32'd9, ALU_ADD, 6);
        rsp_ready = 1'b0;
        clk_edge();
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_res, rsp_ovf, rsp_src, rsp_tag, conflict_cnt} !== '0) begin
            n_err++; $display("FAIL async_reset: got v=%b res=%h cnt=%h expected all 0",
                              rsp_valid, rsp_res, conflict_cnt);
        end
        model_reset();
        clk_edge();
        @(negedge clk);
        rst = 1'b0;
        set_req0(1, 32'd1, 32'd2, ALU_ADD, 1);
        set_req1(1, 32'd3, 32'd4, ALU_ADD, 2);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL post_reset_grant: got r0r1=%b expected 10", {req0_ready, req1_ready});
        end
        clk_edge();
        n_cmp++;
        if ({rsp_valid, rsp_src, rsp_res} !== {1'b1, 1'b0, 32'd3}) begin
            n_err++; $display("FAIL post_reset_rsp: got v=%b src=%b res=%0d expected 1/0/3",
                              rsp_valid, rsp_src, rsp_res);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clk_edge();
    endtask

    task automatic test_random();
        int          g;
        bit          fr;
        logic [67:0] exp_alu;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            set_req0($urandom_range(0, 9) < 6, $urandom, $urandom, 4'($urandom_range(0, 5)), int'($urandom));
            set_req1($urandom_range(0, 9) < 6, $urandom, $urandom, 4'($urandom_range(0, 5)), int'($urandom));
            if ($urandom_range(0, 7) == 0) req1_x = 32'h7FFF_FFFF;
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            g  = pick();
            fr = m_free();
            n_cmp++;
            if ({req0_ready, req1_ready} !== {fr && g == 0, fr && g == 1}) begin
                n_err++; $display("FAIL rand_ready[%0d]: got r0r1=%b expected %b", c,
                                  {req0_ready, req1_ready}, {fr && g == 0, fr && g == 1});
            end
            exp_alu = (g < 0) ? '0 : (g == 1) ? {req1_x, req1_y, req1_op} : {req0_x, req0_y, req0_op};
            n_cmp++;
            if ({alu_x, alu_y, alu_op} !== exp_alu) begin
                n_err++; $display("FAIL rand_alu[%0d]: got %h expected %h", c, {alu_x, alu_y, alu_op}, exp_alu);
            end
            clk_edge();
            n_cmp++;
            if ({dut_rsp(), conflict_cnt} !== {model_rsp(), 16'(m_cnt)}) begin
                n_err++; $display("FAIL rand_rsp[%0d]: got %h cnt %0d expected %h cnt %0d", c,
                                  dut_rsp(), conflict_cnt, model_rsp(), m_cnt);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        clk_edge();
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk);
        set_req0(1, 32'd1, 32'd1, ALU_ADD, 1);
        set_req1(1, 32'd2, 32'd2, ALU_ADD, 2);
        rsp_ready = 1'b1;
        n = 65534 - m_cnt;
        repeat (n) clk_edge();
        n_cmp++;
        if (conflict_cnt !== 16'hFFFE) begin
            n_err++; $display("FAIL sat_preload: got %h expected fffe", conflict_cnt);
        end
        for (int k = 1; k <= 3; k++) begin
            clk_edge();
            n_cmp++;
            if (conflict_cnt !== 16'hFFFF) begin
                n_err++; $display("FAIL sat_hold[%0d]: got %h expected ffff", k, conflict_cnt);
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req0(0, '0, '0, '0, 0);
        set_req1(0, '0, '0, '0, 0);
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester tag carried with each operation.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  operation offered by issue slot N (N = 0, 1).
REQ-005 SHALL have ports reqN_ready  output  1  slot N operation accepted this cycle.
REQ-006 SHALL have ports reqN_x, reqN_y  input  32  operands; reqN_op  input  4  ALU op code from the shared defs header; reqN_tag  input  TAG_W.
REQ-007 SHALL have ports alu_x, alu_y  output  32, and alu_op  output  4, driving the single shared combinational ALU.
REQ-008 SHALL have ports alu_res  input  32, and alu_ovf  input  1, returned by that ALU in the same cycle.
REQ-009 SHALL have port rsp_valid  output  1  registered result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have ports rsp_res  output  32; rsp_ovf  output  1; rsp_src  output  1 (granted slot); rsp_tag  output  TAG_W.
REQ-012 SHALL have port conflict_cnt  output  16  count of cycles in which both slots were valid.

Function
REQ-013 SHALL hold one output register entry; slot "free" = !rsp_valid || rsp_ready.
REQ-014 SHALL grant at most one slot per cycle; with only one slot valid, grant that slot.
REQ-015 With both slots valid, SHALL grant the slot not named by rr_last (round-robin); rr_last resets to 1, so slot 0 wins the first conflict.
REQ-016 SHALL update rr_last to the granted slot only on acceptance (grant && free); no acceptance means no pointer change.
REQ-017 reqN_ready SHALL equal free && grant==N; it is combinational on the valids and rsp_ready.
REQ-018 alu_x/alu_y/alu_op SHALL mux the granted slot's operands; with no valid slot, they SHALL be driven 0 (op 0).
REQ-019 On acceptance, SHALL register alu_res, alu_ovf, granted slot index and tag; rsp_valid=1 on the next edge (latency 1 cycle).
REQ-020 rsp_* contents SHALL stay stable while rsp_valid && !rsp_ready.
REQ-021 On rsp_ready && rsp_valid with no new acceptance, SHALL clear rsp_valid next edge.
REQ-022 Simultaneous drain and accept SHALL load the new result with rsp_valid staying 1 (back-to-back throughput 1 op/cycle).
REQ-023 SHALL pass op codes through unchecked; rsp_ovf is alu_ovf as sampled, never masked.
REQ-024 conflict_cnt SHALL increment when req0_valid && req1_valid, regardless of free, and saturate at 0xFFFF.
REQ-025 Requesters SHALL hold valid and payload until ready; the block SHALL NOT rely on it for correctness of the grant or pointer.

Reset
REQ-026 Asserting rst SHALL immediately force rsp_valid=0, rsp_res=0, rsp_ovf=0, rsp_src=0, rsp_tag=0, rr_last=1, conflict_cnt=0.
REQ-027 reqN_ready SHALL be 0 while rst is high; an in-flight result is discarded, not replayed.
REQ-028 After rst deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-029 Single op: req0 x=5 y=7 op=ALU_ADD tag=3, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, res=12, ovf=0, src=0, tag=3.
REQ-030 Conflict: both valid at cycle 0 and held, rsp_ready=1 -> grants 0,1,0,1 on consecutive cycles; conflict_cnt increments each cycle.
REQ-031 Backpressure: result held with rsp_ready=0 for 3 cycles -> both readys 0, rsp_* unchanged, rr_last unchanged; drain cycle accepts next op with no bubble.
REQ-032 Overflow: req1 x=0x7FFFFFFF y=1 op=ALU_ADD -> res=0x80000000, ovf=1, src=1.
REQ-033 Reset mid-operation: rst pulse while rsp_valid=1 -> rsp_valid=0 without a clock edge; next conflict grants slot 0.
REQ-034 Saturation: conflict_cnt preloaded to 0xFFFE, both valid 3 cycles -> reads 0xFFFF, no wrap to 0.
